// File: rtl/ble_phy_pkg.sv
// Shared constants and FSM encoding for the BLE/BR PHY checksum engines.
package ble_phy_pkg;

  localparam logic [7:0]  HEC_POLY           = 8'hA7;
  localparam logic [23:0] BLE_CRC24_POLY     = 24'h00065B;
  localparam logic [23:0] BLE_CRC24_INIT_ADV = 24'h555555;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SHIFT = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit Galois LFSR step: shift left, fold the polynomial in when MSB ^ data is set.
module crc_lfsr_step #(
  parameter int             N    = 8,
  parameter logic [N-1:0]   POLY = '0
) (
  input  logic [N-1:0] cur,
  input  logic         din,
  output logic [N-1:0] nxt
);

  logic fb;

  assign fb  = cur[N-1] ^ din;
  assign nxt = {cur[N-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_lfsr_bluetooth_ble.sv
// Serial CRC/HEC engine: generate (shift checksum out MSB first) or check (zero remainder).
module crc_lfsr_bluetooth_ble
  import ble_phy_pkg::*;
#(
  parameter int                    CRC_LENGTH   = 8,
  parameter logic [CRC_LENGTH-1:0] POLY         = CRC_LENGTH'(HEC_POLY),
  parameter int                    INIT_REFLECT = 1,
  parameter int                    CNT_W        = $clog2(CRC_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CRC_LENGTH-1:0] init_val,
  input  logic                  load_init,
  input  logic                  mode,
  input  logic                  valid_in,
  input  logic                  data_in,
  input  logic                  last_in,
  input  logic                  out_ready,
  output logic [CRC_LENGTH-1:0] crc_reg,
  output logic                  crc_out,
  output logic                  crc_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_ok,
  output logic [1:0]            state_dbg
);

  // Handshakes: a data bit moves when valid_in is high in IDLE/CALC; a checksum
  // bit moves when crc_valid and out_ready are both high. Neither side waits on the other.

  crc_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CRC_LENGTH-1:0] crc_nxt, step_nxt, seed;
  logic                  mode_q, mode_nxt, ok_nxt, done_nxt, end_mode;

  crc_lfsr_step #(
    .N    (CRC_LENGTH),
    .POLY (POLY)
  ) u_step (
    .cur (crc_reg),
    .din (data_in),
    .nxt (step_nxt)
  );

  always_comb begin
    seed = init_val;
    if (INIT_REFLECT != 0) begin
      for (int i = 0; i < CRC_LENGTH; i++) seed[i] = init_val[CRC_LENGTH-1-i];
    end
  end

  // Mode is taken live on the first bit, from the latch afterwards.
  assign end_mode = (state == ST_IDLE) ? mode : mode_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    crc_nxt   = crc_reg;
    mode_nxt  = mode_q;
    ok_nxt    = crc_ok;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE, ST_CALC: begin
        if (state == ST_IDLE && load_init) begin
          crc_nxt = seed;
          ok_nxt  = 1'b0;
        end else if (valid_in) begin
          crc_nxt = step_nxt;
          if (state == ST_IDLE) begin
            mode_nxt  = mode;
            ok_nxt    = 1'b0;
            state_nxt = ST_CALC;
          end
          if (last_in) begin
            if (end_mode) begin
              ok_nxt    = (step_nxt == '0);
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              cnt_nxt   = CNT_W'(CRC_LENGTH);
              state_nxt = ST_SHIFT;
            end
          end
        end
      end
      ST_SHIFT: begin
        if (out_ready) begin
          crc_nxt = {crc_reg[CRC_LENGTH-2:0], 1'b0};
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      crc_reg <= '0;
      mode_q  <= 1'b0;
      crc_ok  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      crc_reg <= crc_nxt;
      mode_q  <= mode_nxt;
      crc_ok  <= ok_nxt;
      done    <= done_nxt;
    end
  end

  assign crc_out   = crc_reg[CRC_LENGTH-1];
  assign crc_valid = (state == ST_SHIFT);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule
